// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2,
    FAULT  = 2'd3
  } state_e;

  // Operation encoding on the op input
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Width of the cycle counter
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake and control bundle between the main control FSM and the muldiv sequencer.
interface muldiv_sequencer_if;

  logic        start;
  logic        op;
  logic [31:0] divisor;
  logic        abort;
  logic        hilo_rd_req;
  logic        mult_en;
  logic        div_en;
  logic        hilo_load;
  logic        hilo_sel;
  logic        busy;
  logic        done;
  logic        divby0;
  logic        hilo_rd_stall;

  // Control FSM side
  modport master (
    output start, op, divisor, abort, hilo_rd_req,
    input  mult_en, div_en, hilo_load, hilo_sel, busy, done, divby0, hilo_rd_stall
  );

  // Sequencer side
  modport slave (
    input  start, op, divisor, abort, hilo_rd_req,
    output mult_en, div_en, hilo_load, hilo_sel, busy, done, divby0, hilo_rd_stall
  );

endinterface

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter that saturates at zero; zero flag is combinational.
module muldiv_cycle_counter
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; decrement stops at zero so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the multicycle multiplier/divider and the shared Hi/Lo pair.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);

  // Counter is loaded with N-1 so that RUN lasts exactly N cycles.
  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  muldiv_cycle_counter u_cycle_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state logic; abort always returns to IDLE and beats a simultaneous start.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          op_d = bus.op;
          if ((bus.op == OP_DIV) && (bus.divisor == '0)) begin
            state_d = FAULT;
          end else begin
            state_d      = RUN;
            cnt_load     = 1'b1;
            cnt_load_val = (bus.op == OP_DIV) ? DivLoad : MultLoad;
          end
        end
      end
      RUN: begin
        cnt_dec = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and op registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Moore output decode; only the read stall looks at an input.
  always_comb begin
    bus.mult_en   = 1'b0;
    bus.div_en    = 1'b0;
    bus.hilo_load = 1'b0;
    bus.hilo_sel  = 1'b0;
    bus.done      = 1'b0;
    bus.divby0    = 1'b0;
    case (state_q)
      RUN: begin
        bus.mult_en = (op_q == OP_MULT);
        bus.div_en  = (op_q == OP_DIV);
      end
      COMMIT: begin
        bus.hilo_load = 1'b1;
        bus.hilo_sel  = op_q;
        bus.done      = 1'b1;
      end
      FAULT:   bus.divby0 = 1'b1;
      default: ;
    endcase
    bus.busy          = (state_q != IDLE);
    bus.hilo_rd_stall = bus.hilo_rd_req & (state_q != IDLE);
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Controller for the multicycle multiply/divide resource: the shift-add multiplier, the divider and the shared Hi/Lo register pair.
- Accepts a one-cycle start from the main control FSM and holds the selected unit's enable for a fixed cycle count.
- Commits the result into Hi/Lo, or raises the divide-by-zero exception without touching Hi/Lo.
- Provides the busy/stall interlock for the control FSM and for Hi/Lo reads (mfhi/mflo).

Parameters:
- MULT_CYCLES, 32: cycles the multiplier enable is held; legal range 1..255.
- DIV_CYCLES, 32: cycles the divider enable is held; legal range 1..255.

Ports:
- clk, in, 1: clock; all state changes on rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request from control; sampled only in IDLE.
- op, in, 1: 0 = MULT, 1 = DIV; sampled with start.
- divisor, in, 32: divider B operand; zero-checked on the start cycle.
- abort, in, 1: exception/flush; cancels any operation.
- hilo_rd_req, in, 1: control wants to read Hi or Lo this cycle.
- mult_en, out, 1: enable (level) to the multiplier.
- div_en, out, 1: enable (level) to the divider.
- hilo_load, out, 1: load strobe for Hi and Lo.
- hilo_sel, out, 1: Hi/Lo input mux select; 0 = multiplier, 1 = divider.
- busy, out, 1: operation in progress.
- done, out, 1: one-cycle pulse on successful commit.
- divby0, out, 1: one-cycle exception pulse to control.
- hilo_rd_stall, out, 1: the read must be held off.

Behaviour:
- Reset: synchronous, active-high. State is IDLE, counter is 0, op register is 0. All outputs are 0 in the cycle after reset is sampled. Reset overrides every input, including a mid-operation start or abort.
- States: IDLE, RUN, COMMIT, FAULT.
- IDLE, start=1 and abort=0:
  - Latch op.
  - If op=DIV and divisor==0, go to FAULT.
  - Otherwise go to RUN with counter = (op ? DIV_CYCLES : MULT_CYCLES) - 1.
- IDLE, start=0, or start=1 together with abort=1: stay in IDLE. Abort wins.
- RUN:
  - mult_en = ~op_q and div_en = op_q; exactly one is high, the other 0.
  - Counter decrements each cycle.
  - When counter==0, go to COMMIT.
  - RUN lasts exactly N cycles, where N = the parameter for the op.
- COMMIT:
  - hilo_load=1, hilo_sel=op_q, done=1, both enables 0.
  - Always goes to IDLE next cycle.
- FAULT:
  - divby0=1 for one cycle; hilo_load, done and both enables stay 0.
  - Goes to IDLE next cycle.
- abort=1 in RUN, COMMIT or FAULT: go to IDLE next cycle.
  - Outputs are still decoded from the current state in that cycle, so an abort in COMMIT does not suppress that cycle's load.
  - Nothing further is produced.
- busy = (state != IDLE), combinational from state.
- start while busy is ignored; no queueing, no error flag.
- A start in the COMMIT cycle is ignored. Control must wait for busy=0.
- hilo_rd_stall = hilo_rd_req & busy. This stalls through COMMIT, so a read never sees stale Hi/Lo.
- Latency: start sampled at edge t.
  - busy rises after edge t.
  - RUN occupies cycles t+1 .. t+N.
  - COMMIT (hilo_load, done) is in cycle t+N+1.
  - busy is 0 from cycle t+N+2.
- Divide-by-zero latency: start at edge t, divby0 in cycle t+1, busy 0 from cycle t+2.
- Counter width is 8 bits. It never wraps: the counter leaves RUN at 0 and is never decremented below 0.
- Outputs are Moore (decoded from state only), except hilo_rd_stall, which also uses hilo_rd_req.

Decomposition:
- Package muldiv_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, COMMIT=2'd2, FAULT=2'd3.
  - op encoding: OP_MULT=1'b0, OP_DIV=1'b1.
  - CNT_W=8.
- One sub-module, muldiv_cycle_counter: loadable 8-bit down-counter with load, dec and zero flag.
- FSM and output decode remain in muldiv_sequencer.

Test Plan:
- Reset asserted for 2 cycles mid-RUN, then released -> all outputs 0; start with op=0 two cycles later runs a full 32-cycle sequence normally.
- start, op=0 (MULT), MULT_CYCLES=32 at edge t -> mult_en high for cycles t+1..t+32 and div_en stays 0; hilo_load=done=1, hilo_sel=0 at t+33; busy=0 at t+34.
- start, op=1, divisor=32'h0000_0007 -> div_en high for 32 cycles; commit with hilo_sel=1; divby0 never set.
- start, op=1, divisor=32'h0 -> divby0=1 at t+1 only; hilo_load, done, div_en stay 0; busy=0 at t+2.
- Mid-RUN cases, MULT at cycle t+10:
  - second start with op=1 -> ignored; still commits as MULT at t+33.
  - hilo_rd_req=1 from t+5 to t+34 -> stall high through t+33, low at t+34.
- abort at cycle t+15 of a DIV -> IDLE at t+16; no hilo_load, no done; a new start at t+17 is accepted. Also start+abort in the same IDLE cycle -> busy stays 0.
